// File: rtl/prog_memory_pkg.sv
// Shared types and constants for the program memory: FSM state encoding and the NOP word.
package prog_memory_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // Widest instruction word the NOP constant covers; users slice it to DATA_W.
  localparam int            NOP_W    = 64;
  localparam logic [NOP_W-1:0] NOP_WORD = '0;

endpackage

// File: rtl/prog_memory_array.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered read port.
module prog_memory_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rclr,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_p1_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read stage: rclr forces a zero word (reset or out-of-range fetch), otherwise
  // the register only moves on a read so the last instruction is held.
  always_ff @(posedge clk) begin
    if (rclr) begin
      rdata_p1_q <= '0;
    end else if (re) begin
      rdata_p1_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_p1_q;

endmodule

// File: rtl/prog_memory.sv
// Program memory with power-on clear, streaming load sessions and single-cycle-latency fetch.
module prog_memory
  import prog_memory_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              addr_err,
  output logic [ADDR_W:0]   load_count,
  output logic              load_ovf,
  output logic              busy
);

  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("prog_memory: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
  end
  if (DATA_W > NOP_W) begin : g_bad_width
    $error("prog_memory: DATA_W exceeds NOP word width");
  end

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] NOP     = NOP_WORD[DATA_W-1:0];

  state_e          state_q, state_d;
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            vld_p1_q, vld_p1_d;
  logic            err_p1_q, err_p1_d;

  logic              fetch_acc;
  logic              fetch_oob;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              rd_en;
  logic              rd_clr;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    fetch_ready = !rst && (state_q == ST_RUN) && !load_en;
    load_ready  = !rst && (state_q == ST_LOAD);
    fetch_acc   = fetch_valid && fetch_ready;
    fetch_oob   = {1'b0, fetch_addr} >= DEPTH_C;

    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    wdata   = NOP;

    unique case (state_q)
      ST_CLEAR: begin
        we    = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == DEPTH_C - 1'b1) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end
      end
      ST_RUN: begin
        if (load_en) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_valid && load_ready) begin
          // The pointer parks at DEPTH once full; further words only raise the flag.
          if (ptr_q < DEPTH_C) begin
            we    = 1'b1;
            wdata = load_data;
            ptr_d = ptr_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (!load_en) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase

    vld_p1_d = fetch_acc;
    err_p1_d = fetch_acc && fetch_oob;
    rd_en    = fetch_acc && !fetch_oob;
    rd_clr   = rst || (fetch_acc && fetch_oob);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_CLEAR;
      ptr_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      vld_p1_q <= 1'b0;
      err_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      vld_p1_q <= vld_p1_d;
      err_p1_q <= err_p1_d;
    end
  end

  // Fetch stage p0 -> p1 boundary lives inside the array's read register.
  prog_memory_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (ptr_q[ADDR_W-1:0]),
    .wdata (wdata),
    .re    (rd_en),
    .rclr  (rd_clr),
    .raddr (fetch_addr),
    .rdata (rdata)
  );

  assign instr_valid = vld_p1_q && !rst;
  assign addr_err    = err_p1_q && !rst;
  assign instruction = rst ? NOP : rdata;
  assign load_count  = rst ? '0 : cnt_q;
  assign load_ovf    = ovf_q && !rst;
  assign busy        = rst || (state_q != ST_RUN);

endmodule

// File: tb/tb_prog_memory.sv
// Directed bench for prog_memory: a default 32-deep instance and a 20-deep instance.
module tb_prog_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: DEPTH=32
  logic        rst = 1'b1, load_en = 1'b0, load_valid = 1'b0, fetch_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic [4:0]  fetch_addr = '0;
  logic        load_ready, fetch_ready, instr_valid, addr_err, load_ovf, busy;
  logic [31:0] instruction;
  logic [5:0]  load_count;

  // Instance B: DEPTH=20
  logic        rst_b = 1'b1, load_en_b = 1'b0, load_valid_b = 1'b0, fetch_valid_b = 1'b0;
  logic [31:0] load_data_b = '0;
  logic [4:0]  fetch_addr_b = '0;
  logic        load_ready_b, fetch_ready_b, instr_valid_b, addr_err_b, load_ovf_b, busy_b;
  logic [31:0] instruction_b;
  logic [5:0]  load_count_b;

  prog_memory #(.DATA_W(32), .ADDR_W(5), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .instr_valid(instr_valid), .instruction(instruction),
    .addr_err(addr_err), .load_count(load_count), .load_ovf(load_ovf), .busy(busy)
  );

  prog_memory #(.DATA_W(32), .ADDR_W(5), .DEPTH(20)) dut_b (
    .clk(clk), .rst(rst_b), .load_en(load_en_b), .load_valid(load_valid_b),
    .load_data(load_data_b), .load_ready(load_ready_b), .fetch_valid(fetch_valid_b),
    .fetch_addr(fetch_addr_b), .fetch_ready(fetch_ready_b), .instr_valid(instr_valid_b),
    .instruction(instruction_b), .addr_err(addr_err_b), .load_count(load_count_b),
    .load_ovf(load_ovf_b), .busy(busy_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear_a(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({instr_valid, addr_err, instruction, load_count, load_ovf, busy, fetch_ready, load_ready}
        !== {1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got iv=%b ae=%b ins=%h cnt=%0d ovf=%b busy=%b fr=%b lr=%b want 0 0 0 0 0 1 0 0",
               instr_valid, addr_err, instruction, load_count, load_ovf, busy, fetch_ready, load_ready);
    end
    rst = 1'b0;
    #1;
    begin
      int n;
      wait_clear_a(n);
      checks++;
      if (n != 32) begin
        errors++;
        $display("FAIL clear_cycles got %0d want 32", n);
      end
    end
    checks++;
    if (fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_clear got %b want 1", fetch_ready);
    end
  endtask

  task automatic test_clear_contents;
    int bad = 0;
    for (int i = 0; i < 32; i++) begin
      fetch_valid = 1'b1;
      fetch_addr  = 5'(i);
      tick();
      if (instr_valid !== 1'b1 || instruction !== 32'h0 || addr_err !== 1'b0) bad++;
    end
    fetch_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_contents got %0d bad reads want 0", bad);
    end
  endtask

  task automatic test_load;
    logic [31:0] words [3];
    words[0] = 32'h18000A0A;
    words[1] = 32'h180F000F;
    words[2] = 32'h08AF6400;
    load_en = 1'b1;
    tick();
    checks++;
    if (load_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_entry got lr=%b busy=%b want 1 1", load_ready, busy);
    end
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = words[i];
      tick();
    end
    load_valid = 1'b0;
    load_en    = 1'b0;
    tick();
    checks++;
    if (load_count !== 6'd3 || busy !== 1'b0 || load_ovf !== 1'b0) begin
      errors++;
      $display("FAIL load_count got cnt=%0d busy=%b ovf=%b want 3 0 0", load_count, busy, load_ovf);
    end
    fetch_valid = 1'b1;
    fetch_addr  = 5'd2;
    tick();
    fetch_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instruction !== 32'h08AF6400) begin
      errors++;
      $display("FAIL fetch_addr2 got iv=%b ins=%h want 1 08af6400", instr_valid, instruction);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0 || instruction !== 32'h08AF6400) begin
      errors++;
      $display("FAIL instr_hold got iv=%b ins=%h want 0 08af6400", instr_valid, instruction);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [3];
    exp[0] = 32'h18000A0A;
    exp[1] = 32'h180F000F;
    exp[2] = 32'h08AF6400;
    for (int i = 0; i < 3; i++) begin
      fetch_valid = 1'b1;
      fetch_addr  = 5'(i);
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instruction !== exp[i]) begin
        errors++;
        $display("FAIL b2b_%0d got iv=%b ins=%h want 1 %h", i, instr_valid, instruction, exp[i]);
      end
    end
    fetch_valid = 1'b0;
    tick();
  endtask

  task automatic test_conflict;
    load_en     = 1'b1;
    fetch_valid = 1'b1;
    fetch_addr  = 5'd0;
    #1;
    checks++;
    if (fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL conflict_ready got %b want 0", fetch_ready);
    end
    tick();
    fetch_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || load_ready !== 1'b1 || load_count !== 6'd0) begin
      errors++;
      $display("FAIL conflict_load got iv=%b lr=%b cnt=%0d want 0 1 0", instr_valid, load_ready, load_count);
    end
    load_en = 1'b0;
    tick();
    fetch_valid = 1'b1;
    fetch_addr  = 5'd1;
    tick();
    fetch_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instruction !== 32'h180F000F) begin
      errors++;
      $display("FAIL persist got iv=%b ins=%h want 1 180f000f", instr_valid, instruction);
    end
  endtask

  task automatic test_reset_flight;
    fetch_valid = 1'b1;
    fetch_addr  = 5'd0;
    tick();
    fetch_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || fetch_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_flight got iv=%b fr=%b busy=%b want 0 0 1", instr_valid, fetch_ready, busy);
    end
    tick();
    rst = 1'b0;
    #1;
    begin
      int n;
      wait_clear_a(n);
      checks++;
      if (n != 32) begin
        errors++;
        $display("FAIL reclear_cycles got %0d want 32", n);
      end
    end
  endtask

  task automatic test_reset_mid_load;
    int bad = 0;
    load_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hC0DE0100 + 32'(i);
      tick();
    end
    checks++;
    if (load_count !== 6'd5) begin
      errors++;
      $display("FAIL mid_load_count got %0d want 5", load_count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b0 || load_count !== 6'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_load_rst got lr=%b cnt=%0d busy=%b want 0 0 1", load_ready, load_count, busy);
    end
    tick();
    rst        = 1'b0;
    load_en    = 1'b0;
    load_valid = 1'b0;
    #1;
    begin
      int n;
      wait_clear_a(n);
      checks++;
      if (n != 32) begin
        errors++;
        $display("FAIL mid_load_clear got %0d want 32", n);
      end
    end
    for (int i = 0; i < 32; i++) begin
      fetch_valid = 1'b1;
      fetch_addr  = 5'(i);
      tick();
      if (instr_valid !== 1'b1 || instruction !== 32'h0) bad++;
    end
    fetch_valid = 1'b0;
    checks++;
    if (bad != 0 || load_count !== 6'd0) begin
      errors++;
      $display("FAIL mid_load_zero got bad=%0d cnt=%0d want 0 0", bad, load_count);
    end
  endtask

  task automatic test_depth20;
    int n = 0;
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    #1;
    while (busy_b === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL d20_clear_cycles got %0d want 20", n);
    end
    load_en_b = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      load_valid_b = 1'b1;
      load_data_b  = 32'hA0000000 + 32'(k);
      tick();
    end
    checks++;
    if (load_count_b !== 6'd20 || load_ovf_b !== 1'b0) begin
      errors++;
      $display("FAIL d20_full got cnt=%0d ovf=%b want 20 0", load_count_b, load_ovf_b);
    end
    load_data_b = 32'hA0000015;
    tick();
    load_valid_b = 1'b0;
    load_en_b    = 1'b0;
    tick();
    checks++;
    if (load_count_b !== 6'd20 || load_ovf_b !== 1'b1 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL d20_ovf got cnt=%0d ovf=%b busy=%b want 20 1 0", load_count_b, load_ovf_b, busy_b);
    end
    fetch_valid_b = 1'b1;
    fetch_addr_b  = 5'd19;
    tick();
    checks++;
    if (instr_valid_b !== 1'b1 || instruction_b !== 32'hA0000014 || addr_err_b !== 1'b0) begin
      errors++;
      $display("FAIL d20_addr19 got iv=%b ins=%h ae=%b want 1 a0000014 0", instr_valid_b, instruction_b, addr_err_b);
    end
    fetch_addr_b = 5'd25;
    tick();
    checks++;
    if (instr_valid_b !== 1'b1 || instruction_b !== 32'h0 || addr_err_b !== 1'b1) begin
      errors++;
      $display("FAIL d20_addr25 got iv=%b ins=%h ae=%b want 1 0 1", instr_valid_b, instruction_b, addr_err_b);
    end
    fetch_addr_b = 5'd20;
    tick();
    fetch_valid_b = 1'b0;
    checks++;
    if (instruction_b !== 32'h0 || addr_err_b !== 1'b1) begin
      errors++;
      $display("FAIL d20_addr20 got ins=%h ae=%b want 0 1", instruction_b, addr_err_b);
    end
    tick();
    checks++;
    if (addr_err_b !== 1'b0 || instr_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL d20_err_pulse got ae=%b iv=%b want 0 0", addr_err_b, instr_valid_b);
    end
  endtask

  initial begin
    test_reset();
    test_clear_contents();
    test_load();
    test_back_to_back();
    test_conflict();
    test_reset_flight();
    test_reset_mid_load();
    test_depth20();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_memory.md
PROG_MEMORY -- requirements
Module: prog_memory

Interface
REQ-001 Parameter DATA_W, 32, instruction word width in bits.
REQ-002 Parameter ADDR_W, 5, fetch address width in bits.
REQ-003 Parameter DEPTH, 32, number of stored words; the block SHALL only accept values where 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 load_en  input  1  level request for load mode.
REQ-008 load_valid  input  1  load word present.
REQ-009 load_data  input  DATA_W  word to store at the load pointer.
REQ-010 load_ready  output  1  load word accepted this cycle when high with load_valid.
REQ-011 fetch_valid  input  1  fetch request.
REQ-012 fetch_addr  input  ADDR_W  word address to read.
REQ-013 fetch_ready  output  1  fetch accepted this cycle when high with fetch_valid.
REQ-014 instr_valid  output  1  instruction holds read data (one-cycle pulse).
REQ-015 instruction  output  DATA_W  read data.
REQ-016 addr_err  output  1  pulse, coincident with instr_valid, for fetch_addr >= DEPTH.
REQ-017 load_count  output  ADDR_W+1  words written in the current or last load session.
REQ-018 load_ovf  output  1  sticky flag: a load word arrived with the pointer at DEPTH.
REQ-019 busy  output  1  high in CLEAR and LOAD.

Function
REQ-020 The FSM SHALL have three states: CLEAR, RUN and LOAD.
REQ-021 CLEAR SHALL write zero (NOP) to addresses 0..DEPTH-1, one per cycle, then go to RUN, for exactly DEPTH cycles.
REQ-022 RUN SHALL go to LOAD when load_en=1; LOAD SHALL go to RUN in the cycle after load_en=0 is sampled.
REQ-023 fetch_ready SHALL be (state==RUN && !load_en), so load_en wins a simultaneous request.
REQ-024 An accepted fetch SHALL produce instr_valid=1 with instruction=mem[fetch_addr] exactly one cycle later; back-to-back fetches SHALL sustain one per cycle.
REQ-025 A fetch with fetch_addr >= DEPTH SHALL return instruction=0 and addr_err=1.
REQ-026 When instr_valid=0, instruction SHALL hold its last value.
REQ-027 load_ready SHALL be (state==LOAD).
REQ-028 Each accepted load word SHALL be written at the pointer, and the pointer and load_count SHALL each increment by 1.
REQ-029 On RUN->LOAD entry, the pointer and load_count SHALL clear to 0, and load_ovf SHALL clear.
REQ-030 A load word arriving with the pointer at DEPTH SHALL be dropped and SHALL set load_ovf; the pointer SHALL not wrap.
REQ-031 load_count SHALL hold its final value after LOAD exits until the next LOAD entry.
REQ-032 Memory contents SHALL persist across RUN/LOAD transitions; only reset clears them.

Reset
REQ-033 rst=1 SHALL force state CLEAR and restart clearing from address 0, from any state, including mid-CLEAR and mid-LOAD.
REQ-034 Under rst, the outputs SHALL take these values: instr_valid=0, addr_err=0, instruction=0, load_count=0, load_ovf=0, busy=1, fetch_ready=0, load_ready=0.
REQ-035 Any fetch in flight at reset SHALL be discarded.

Structure
REQ-036 Package prog_memory_pkg SHALL hold the state enum (CLEAR, RUN, LOAD) and the NOP word constant (all zeros).
REQ-037 Storage SHALL live in one sub-module, prog_memory_array, with DEPTH x DATA_W, one synchronous write port and one synchronous read port; FSM, pointer and flags SHALL be in prog_memory.

Verification
REQ-038 Reset, then wait: busy=1 for exactly 32 cycles, then fetch_ready=1; fetching addresses 0..31 returns 0 with no addr_err.
REQ-039 Load 0x18000A0A, 0x180F000F, 0x08AF6400, then fetch address 2 -> instruction=0x08AF6400 one cycle after acceptance; load_count=3.
REQ-040 Issue back-to-back fetches of addresses 0,1,2 on consecutive cycles -> three consecutive instr_valid pulses with the matching words.
REQ-041 With DEPTH=20 and ADDR_W=5, fetch address 25 -> instruction=0, addr_err=1; load 21 words -> load_count=20, load_ovf=1, and address 19 holds word 20.
REQ-042 Assert load_en and fetch_valid together in RUN -> fetch_ready=0 and no instr_valid; LOAD is entered next cycle.
REQ-043 Assert rst after 5 load words -> CLEAR restarts; after 32 cycles all addresses read 0 and load_count=0.
